prio_encoder_8to3: RTL and testbench
====================================

// Module: prio_encoder_8to3
// PURPOSE
//  Sequential 8:3 priority encoder, the inverse of the 3:8 one-hot decoder.
//  Latches request events on 8 input lines into a pending register and
//  presents the highest-priority pending line as a 3-bit code.
//  The code is delivered over a valid/ready handshake, and each accepted
//  code clears its pending bit.
//  Sits between raw request/interrupt lines and any consumer of a binary
//  index, for example a decoder that drives one-hot grant lines.
// PARAMETERS
//  HIGH_FIRST  1  1: bit 7 has highest priority; 0: bit 0 has highest priority
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  synchronous, active-high reset
//  req        in   8  request lines; each high bit in a cycle is one event for that line
//  code       out  3  binary index of the presented request (registered)
//  onehot     out  8  one-hot form of code, equal to decode(code); 0 when valid=0
//  valid      out  1  code/onehot hold a pending request
//  ready      in   1  consumer accepts code when valid&&ready at a rising edge
//  pending    out  8  current pending-request register (debug/status)
//  overrun    out  1  1-cycle pulse: a req bit arrived while that bit was already pending
// BEHAVIOUR
//  Reset: on rst=1 at an edge, pending=0, code=0, onehot=0, valid=0, overrun=0.
//   rst takes priority over every other event in that cycle.
//  Pending update at each edge: pend_n = (pending & ~clr) | req.
//   clr = onehot when valid&&ready, otherwise 0.
//   A req bit equal to the bit being accepted in the same cycle stays set
//   in pend_n, because it is a new event.
//  Latency: a req event sampled at edge N gives valid=1 in cycle N+1,
//   provided no hold is active.
//  Output register update at each edge:
//   - Hold: if valid && !ready, code, onehot and valid stay unchanged.
//     New requests still accumulate in pending.
//     Higher-priority arrivals do not pre-empt a presented code.
//   - Otherwise: valid <= |pend_n.
//     code <= index of the highest-priority set bit of pend_n.
//     HIGH_FIRST=1: highest index wins. HIGH_FIRST=0: lowest index wins.
//     onehot <= 1<<code when valid, else 0.
//  Empty: pend_n=0 and no hold gives valid=0, code=0, onehot=0.
//  Back-to-back: with ready held at 1, one code is accepted per cycle and
//   the next code is presented in the cycle after the accept.
//   Draining all 8 bits takes 8 accepts.
//  overrun <= |(req & pending & ~clr), registered one cycle after the
//   colliding req. The duplicate event is merged, not queued.
//  ready while valid=0 has no effect. X on ready is not permitted after reset.
//  Invariant: when valid=1, pending[code]=1 and onehot has exactly one bit set.
// TESTING
//  1 Reset: drive req=8'hFF with rst=1 for 2 cycles, then rst=0 -> valid=0
//    and pending=0 while rst=1; valid=1, code=7 one cycle after rst falls.
//  2 Single event: req=8'b0000_0100 for 1 cycle, ready=1 -> next cycle
//    valid=1, code=2, onehot=8'h04; the following cycle valid=0, pending=0.
//  3 Priority drain: req=8'hA5 pulse, ready=1, HIGH_FIRST=1 -> codes 7,5,2,0
//    on consecutive cycles, then valid=0. Repeat with HIGH_FIRST=0 -> codes 0,2,5,7.
//  4 Hold/no pre-empt: req=8'h02, ready=0 -> code=1. Then pulse req=8'h80 ->
//    code stays 1 and pending=8'h82. Raise ready -> code 1 accepted, then code=7.
//  5 Accept+re-arm and overrun: pending=8'h08, code=3, valid&&ready with
//    req=8'h08 in the same cycle -> pending stays 8'h08, valid=1, code=3,
//    overrun=0. With ready=0 and req=8'h08 again -> overrun=1 for exactly 1 cycle.
//  6 Reset mid-operation: pending=8'hFF, valid=1, assert rst for 1 cycle ->
//    all outputs 0 the next cycle; no stale code appears after rst falls.

Source files
------------

// File: rtl/prio_encoder_8to3.sv
// prio_encoder_8to3
//   Sequential 8:3 priority encoder. Request events on eight lines are
//   collected in a pending register. The highest-priority pending line is
//   presented as a registered 3-bit code with its one-hot form, over a
//   valid/ready handshake. Each accepted code clears its pending bit.
//
// Parameters
//   HIGH_FIRST  1: bit 7 has the highest priority; 0: bit 0 has the highest priority
//
// Ports
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous, active-high reset
//   req      in   8  request lines; each high bit in a cycle is one event
//   code     out  3  binary index of the presented request (registered)
//   onehot   out  8  one-hot form of code; 0 when valid=0
//   valid    out  1  code/onehot hold a pending request
//   ready    in   1  consumer accepts code when valid && ready at a rising edge
//   pending  out  8  current pending-request register
//   overrun  out  1  1-cycle pulse: a req bit arrived while already pending
module prio_encoder_8to3 #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [2:0] code,
  output logic [7:0] onehot,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pending,
  output logic       overrun
);

  // Index of the winning set bit; 0 when the vector is empty.
  // The scan direction makes the last match seen the highest-priority one.
  function automatic logic [2:0] pick_index(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 8; i++) begin
        if (vec[i]) idx = 3'(i);
        else        idx = idx;
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (vec[i]) idx = 3'(i);
        else        idx = idx;
      end
    end
    return idx;
  endfunction

  // 3:8 one-hot decode of a binary index.
  function automatic logic [7:0] decode(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction

  logic [2:0] code_r;
  logic [7:0] onehot_r;
  logic       valid_r;
  logic [7:0] pending_r;
  logic       overrun_r;

  logic [7:0] clr_s;
  logic [7:0] pend_n_s;
  logic       hold_s;
  logic       any_s;
  logic [2:0] next_code_s;
  logic       overrun_n_s;

  // Next-state terms: accept-clear mask, merged pending vector, hold and overrun.
  always_comb begin
    clr_s       = 8'h00;
    hold_s      = 1'b0;
    if (valid_r && ready) begin
      clr_s = onehot_r;
    end else begin
      clr_s = 8'h00;
    end
    if (valid_r && !ready) begin
      hold_s = 1'b1;
    end else begin
      hold_s = 1'b0;
    end
    // A req on the bit being accepted survives: it is a fresh event.
    pend_n_s    = (pending_r & ~clr_s) | req;
    any_s       = |pend_n_s;
    next_code_s = pick_index(pend_n_s);
    // Duplicate events are merged into the existing pending bit and flagged.
    overrun_n_s = |(req & pending_r & ~clr_s);
  end

  // State and output registers; a presented code is frozen while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= 8'h00;
      code_r    <= 3'd0;
      onehot_r  <= 8'h00;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      pending_r <= pend_n_s;
      overrun_r <= overrun_n_s;
      if (!hold_s) begin
        valid_r <= any_s;
        if (any_s) begin
          code_r   <= next_code_s;
          onehot_r <= decode(next_code_s);
        end else begin
          code_r   <= 3'd0;
          onehot_r <= 8'h00;
        end
      end else begin
        valid_r  <= valid_r;
        code_r   <= code_r;
        onehot_r <= onehot_r;
      end
    end
  end

  assign code    = code_r;
  assign onehot  = onehot_r;
  assign valid   = valid_r;
  assign pending = pending_r;
  assign overrun = overrun_r;

endmodule

// File: tb/tb_prio_encoder_8to3.sv
// tb_prio_encoder_8to3
//   Drives two encoder instances (HIGH_FIRST=1 and HIGH_FIRST=0) with shared
//   stimulus: directed scenarios followed by random traffic, comparing every
//   output against a per-line event model held in the bench.
module tb_prio_encoder_8to3;

  logic clk;
  logic rst;
  logic [7:0] req;
  logic ready;

  // Index 1: HIGH_FIRST=1 instance, index 0: HIGH_FIRST=0 instance.
  logic [1:0][2:0] code_w;
  logic [1:0][7:0] onehot_w;
  logic [1:0]      valid_w;
  logic [1:0][7:0] pending_w;
  logic [1:0]      overrun_w;

  int checks = 0;
  int failures = 0;

  // Reference model: one flag per request line plus the presented line.
  bit mp[2][8];
  int mcode[2];
  bit mvalid[2];
  bit movr[2];

  prio_encoder_8to3 #(.HIGH_FIRST(1'b1)) dut_hi (
    .clk(clk), .rst(rst), .req(req), .code(code_w[1]), .onehot(onehot_w[1]),
    .valid(valid_w[1]), .ready(ready), .pending(pending_w[1]), .overrun(overrun_w[1])
  );

  prio_encoder_8to3 #(.HIGH_FIRST(1'b0)) dut_lo (
    .clk(clk), .rst(rst), .req(req), .code(code_w[0]), .onehot(onehot_w[0]),
    .valid(valid_w[0]), .ready(ready), .pending(pending_w[0]), .overrun(overrun_w[0])
  );

  always #5 clk = ~clk;

  // Advance the model by one clock edge with the inputs applied to it.
  task automatic model_edge(input int h, input logic [7:0] r, input logic rd, input logic rs);
    bit accept;
    int best;
    if (rs) begin
      for (int i = 0; i < 8; i++) mp[h][i] = 1'b0;
      mcode[h] = 0; mvalid[h] = 1'b0; movr[h] = 1'b0;
    end else begin
      accept = mvalid[h] && rd;
      movr[h] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        bit taken;
        taken = accept && (i == mcode[h]);
        if (r[i] && mp[h][i] && !taken) movr[h] = 1'b1;
        if (taken) mp[h][i] = 1'b0;
        if (r[i]) mp[h][i] = 1'b1;
      end
      if (!(mvalid[h] && !rd)) begin
        best = -1;
        for (int k = 0; k < 8; k++) begin
          int i;
          i = (h == 1) ? 7 - k : k;
          if (best < 0 && mp[h][i]) best = i;
        end
        mvalid[h] = (best >= 0);
        mcode[h] = (best >= 0) ? best : 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] ep;
    logic [7:0] eo;
    for (int h = 0; h < 2; h++) begin
      ep = 8'h00;
      for (int i = 0; i < 8; i++) if (mp[h][i]) ep = ep | (8'd1 << i);
      eo = mvalid[h] ? (8'd1 << mcode[h]) : 8'h00;
      checks++;
      assert (valid_w[h] === mvalid[h]) else begin
        failures++; $error("FAIL %s valid h%0d: got %b want %b", tag, h, valid_w[h], mvalid[h]);
      end
      checks++;
      assert (code_w[h] === 3'(mcode[h])) else begin
        failures++; $error("FAIL %s code h%0d: got %0d want %0d", tag, h, code_w[h], mcode[h]);
      end
      checks++;
      assert (onehot_w[h] === eo) else begin
        failures++; $error("FAIL %s onehot h%0d: got %h want %h", tag, h, onehot_w[h], eo);
      end
      checks++;
      assert (pending_w[h] === ep) else begin
        failures++; $error("FAIL %s pending h%0d: got %h want %h", tag, h, pending_w[h], ep);
      end
      checks++;
      assert (overrun_w[h] === movr[h]) else begin
        failures++; $error("FAIL %s overrun h%0d: got %b want %b", tag, h, overrun_w[h], movr[h]);
      end
    end
  endtask

  // Explicit scenario value from the directed descriptions.
  task automatic expect_code(input int h, input logic ev, input logic [2:0] ec, input string tag);
    checks++;
    assert (valid_w[h] === ev && (!ev || code_w[h] === ec)) else begin
      failures++;
      $error("FAIL %s h%0d: got valid=%b code=%0d want valid=%b code=%0d", tag, h, valid_w[h], code_w[h], ev, ec);
    end
  endtask

  task automatic step(input logic [7:0] r, input logic rd, input logic rs, input string tag);
    req = r; ready = rd; rst = rs;
    @(posedge clk);
    model_edge(0, r, rd, rs);
    model_edge(1, r, rd, rs);
    #1;
    check_all(tag);
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 12; n++) begin
      if (mvalid[0] || mvalid[1]) step(8'h00, 1'b1, 1'b0, tag);
    end
  endtask

  initial begin
    logic [7:0] r;
    logic rd;
    logic rs;
    clk = 1'b0; rst = 1'b1; req = 8'h00; ready = 1'b0;
    for (int h = 0; h < 2; h++) model_edge(h, 8'h00, 1'b0, 1'b1);

    // 1 reset with all requests high
    step(8'hFF, 1'b0, 1'b1, "rst_a");
    step(8'hFF, 1'b0, 1'b1, "rst_b");
    expect_code(1, 1'b0, 3'd0, "rst_held");
    step(8'hFF, 1'b0, 1'b0, "rst_rel");
    expect_code(1, 1'b1, 3'd7, "rst_rel_hi");
    expect_code(0, 1'b1, 3'd0, "rst_rel_lo");
    drain("rst_drain");

    // 2 single event
    step(8'h04, 1'b1, 1'b0, "single");
    expect_code(1, 1'b1, 3'd2, "single_code");
    step(8'h00, 1'b1, 1'b0, "single_done");
    expect_code(1, 1'b0, 3'd0, "single_empty");

    // 3 priority drain of 8'hA5
    step(8'hA5, 1'b1, 1'b0, "drain0");
    expect_code(1, 1'b1, 3'd7, "drain0_hi"); expect_code(0, 1'b1, 3'd0, "drain0_lo");
    step(8'h00, 1'b1, 1'b0, "drain1");
    expect_code(1, 1'b1, 3'd5, "drain1_hi"); expect_code(0, 1'b1, 3'd2, "drain1_lo");
    step(8'h00, 1'b1, 1'b0, "drain2");
    expect_code(1, 1'b1, 3'd2, "drain2_hi"); expect_code(0, 1'b1, 3'd5, "drain2_lo");
    step(8'h00, 1'b1, 1'b0, "drain3");
    expect_code(1, 1'b1, 3'd0, "drain3_hi"); expect_code(0, 1'b1, 3'd7, "drain3_lo");
    step(8'h00, 1'b1, 1'b0, "drain4");
    expect_code(1, 1'b0, 3'd0, "drain4_hi"); expect_code(0, 1'b0, 3'd0, "drain4_lo");

    // 4 hold, no pre-emption
    step(8'h02, 1'b0, 1'b0, "hold_a");
    expect_code(1, 1'b1, 3'd1, "hold_a_hi");
    step(8'h80, 1'b0, 1'b0, "hold_b");
    expect_code(1, 1'b1, 3'd1, "hold_b_hi");
    step(8'h00, 1'b1, 1'b0, "hold_c");
    expect_code(1, 1'b1, 3'd7, "hold_c_hi");
    drain("hold_drain");

    // 5 accept with re-arm, then overrun while stalled
    step(8'h08, 1'b0, 1'b0, "rearm_a");
    step(8'h08, 1'b1, 1'b0, "rearm_b");
    expect_code(1, 1'b1, 3'd3, "rearm_b_hi");
    step(8'h08, 1'b0, 1'b0, "ovr_a");
    checks++;
    assert (overrun_w === 2'b11) else begin
      failures++; $error("FAIL ovr_pulse: got %b want 11", overrun_w);
    end
    step(8'h00, 1'b0, 1'b0, "ovr_b");
    drain("ovr_drain");

    // 6 reset mid-operation
    step(8'hFF, 1'b0, 1'b0, "mid_a");
    step(8'h00, 1'b0, 1'b1, "mid_rst");
    step(8'h00, 1'b0, 1'b0, "mid_after");
    expect_code(1, 1'b0, 3'd0, "mid_no_stale");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      r = 8'($urandom) & 8'($urandom);
      rd = 1'($urandom_range(0, 2) != 0);
      rs = 1'($urandom_range(0, 63) == 0);
      step(r, rd, rs, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
